// File: rtl/morse_symbol_segmenter.sv
// Times key marks/spaces on ce ticks, packs dits/dahs into a character and
// strobes one event per finished character and one per word end.
module morse_symbol_segmenter #(
    parameter int MAX_LEN        = 6,
    parameter int LEN_W          = 3,
    parameter int CNT_W          = 8,
    parameter int DAH_TICKS      = 3,
    parameter int CHAR_GAP_TICKS = 3,
    parameter int WORD_GAP_TICKS = 7,
    parameter int STUCK_TICKS    = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               key,
    output logic [MAX_LEN-1:0] dits_dahs,
    output logic [LEN_W-1:0]   len,
    output logic               word_end,
    output logic               error,
    output logic               valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MARK  = 2'd1;
    localparam logic [1:0] SPACE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam logic [CNT_W-1:0] DAH_C   = CNT_W'(DAH_TICKS);
    localparam logic [CNT_W-1:0] CHAR_C  = CNT_W'(CHAR_GAP_TICKS);
    localparam logic [CNT_W-1:0] WORD_C  = CNT_W'(WORD_GAP_TICKS);
    localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(STUCK_TICKS);
    localparam logic [LEN_W-1:0] MAX_C   = LEN_W'(MAX_LEN);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [MAX_LEN-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]   buf_len_q, buf_len_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d;
    logic [MAX_LEN-1:0] dits_dahs_q, dits_dahs_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               word_end_q, word_end_d;
    logic               error_q, error_d;

    // Duration counter saturates so a stuck key never wraps back to a dit.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        buf_len_d   = buf_len_q;
        err_d       = err_q;
        valid_d     = 1'b0;
        dits_dahs_d = dits_dahs_q;
        len_d       = len_q;
        word_end_d  = word_end_q;
        error_d     = error_q;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (key) begin
                        state_d = MARK;
                        cnt_d   = CNT_W'(1);
                    end
                end
                MARK: begin
                    if (key) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= STUCK_C) err_d = 1'b1;
                    end else begin
                        if (buf_len_q < MAX_C) begin
                            buf_d[buf_len_q] = (cnt_q >= DAH_C);
                            buf_len_d        = buf_len_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = SPACE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                SPACE: begin
                    if (key) begin
                        state_d = MARK;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CHAR_C) begin
                            valid_d     = 1'b1;
                            dits_dahs_d = buf_q;
                            len_d       = buf_len_q;
                            error_d     = err_q;
                            word_end_d  = 1'b0;
                            buf_d       = '0;
                            buf_len_d   = '0;
                            err_d       = 1'b0;
                            state_d     = GAP;
                        end
                    end
                end
                default: begin
                    if (key) begin
                        state_d = MARK;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == WORD_C) begin
                            valid_d     = 1'b1;
                            dits_dahs_d = '0;
                            len_d       = '0;
                            error_d     = 1'b0;
                            word_end_d  = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            buf_q       <= '0;
            buf_len_q   <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            dits_dahs_q <= '0;
            len_q       <= '0;
            word_end_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            buf_len_q   <= buf_len_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            dits_dahs_q <= dits_dahs_d;
            len_q       <= len_d;
            word_end_q  <= word_end_d;
            error_q     <= error_d;
        end
    end

    assign valid     = valid_q;
    assign dits_dahs = dits_dahs_q;
    assign len       = len_q;
    assign word_end  = word_end_q;
    assign error     = error_q;

endmodule

// File: tb/tb_morse_symbol_segmenter.sv
// Directed bench for morse_symbol_segmenter: key patterns with hand-derived
// character/word strobes.
module tb_morse_symbol_segmenter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       key = 1'b0;
  logic [5:0] dits_dahs;
  logic [2:0] len;
  logic       word_end, error, valid;

  int total = 0;
  int bad = 0;
  int n_strb = 0;
  int run = 0;
  int max_run = 0;
  int n0;
  bit ce_div = 1'b0;
  logic [5:0] c_dd;
  logic [2:0] c_len;
  logic c_we, c_err;

  morse_symbol_segmenter dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .key(key),
    .dits_dahs(dits_dahs), .len(len), .word_end(word_end),
    .error(error), .valid(valid)
  );

  always #5 clk = ~clk;

  // strobe monitor, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (valid) begin
      n_strb++;
      run++;
      if (run > max_run) max_run = run;
      c_dd = dits_dahs; c_len = len; c_we = word_end; c_err = error;
    end else run = 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic k, input int n);
    repeat (n) begin
      key = k; ce = 1'b1;
      @(negedge clk);
      if (ce_div) begin
        ce = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
  endtask

  task automatic settle();
    ce = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_a();
    send(1, 1); send(0, 1); send(1, 3); send(0, 3);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_dd", dits_dahs, 0);
    chk("rst_len", len, 0);
    chk("rst_we", word_end, 0);
    chk("rst_err", error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // "A"
    n0 = n_strb;
    send_a(); settle();
    chk("a_cnt", n_strb - n0, 1);
    chk("a_dd", c_dd, 6'b000010);
    chk("a_len", c_len, 2);
    chk("a_err", c_err, 0);
    chk("a_we", c_we, 0);
    chk("a_width", max_run, 1);

    // word end after 7 silent ticks total
    send(0, 4); settle();
    chk("we_cnt", n_strb - n0, 2);
    chk("we_flag", c_we, 1);
    chk("we_len", c_len, 0);
    chk("we_dd", c_dd, 0);
    chk("we_idle", dut.state_q, 0);
    send(0, 10); settle();
    chk("idle_quiet", n_strb - n0, 2);

    // seven dits overflow
    n0 = n_strb;
    repeat (7) begin send(1, 1); send(0, 1); end
    send(0, 3); settle();
    chk("ovf_cnt", n_strb - n0, 1);
    chk("ovf_len", c_len, 6);
    chk("ovf_dd", c_dd, 0);
    chk("ovf_err", c_err, 1);
    send(0, 8); settle();

    // 2-tick mark is a dit, 3-tick mark is a dah
    send(1, 2); send(0, 3); settle();
    chk("m2_dd", c_dd, 6'b000000);
    chk("m2_len", c_len, 1);
    send(0, 8);
    send(1, 3); send(0, 3); settle();
    chk("m3_dd", c_dd, 6'b000001);
    chk("m3_len", c_len, 1);
    send(0, 8); settle();

    // 2-tick space does not split a character
    n0 = n_strb;
    send(1, 1); send(0, 2); send(1, 1); send(0, 3); settle();
    chk("sp2_cnt", n_strb - n0, 1);
    chk("sp2_len", c_len, 2);
    chk("sp2_dd", c_dd, 0);
    send(0, 8); settle();

    // stuck key, then clean "E"
    send(1, 250); send(0, 3); settle();
    chk("stk_len", c_len, 1);
    chk("stk_dd", c_dd, 6'b000001);
    chk("stk_err", c_err, 1);
    send(1, 1); send(0, 3); settle();
    chk("e_err", c_err, 0);
    chk("e_len", c_len, 1);
    chk("e_dd", c_dd, 0);
    send(0, 8); settle();

    // ce every 4th clk
    ce_div = 1'b1;
    n0 = n_strb; max_run = 0;
    send_a(); settle();
    chk("div_cnt", n_strb - n0, 1);
    chk("div_dd", c_dd, 6'b000010);
    chk("div_len", c_len, 2);
    chk("div_width", max_run, 1);
    ce_div = 1'b0;

    // async reset mid-character
    send(0, 8); settle();
    send(1, 1); send(0, 1); send(1, 1); send(0, 1);
    n0 = n_strb;
    rst_n = 1'b0;
    #1;
    chk("ar_len", len, 0);
    chk("ar_dd", dits_dahs, 0);
    chk("ar_valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 10); settle();
    chk("ar_nostrb", n_strb - n0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
